benes_cfg_sequencer: RTL and testbench

BENES_CFG_SEQUENCER -- requirements
Module: benes_cfg_sequencer

---
 rtl/benes_cfg_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_benes_cfg_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// benes_cfg_sequencer
//
// Steps a Benes network through a programmed list of permutations. A small
// table holds one permutation word per entry (one switch_set bit per 2x2
// switch, stage s at bits [s*SWITCH_NUM +: SWITCH_NUM]). On start the
// sequencer applies entries 0..last_idx in order, holding each one on
// switch_selection for dwell+1 cycles with cfg_valid high, and drops
// cfg_valid for exactly one cycle (LOAD) between entries.
//
// Optional feature: define BENES_CFG_LOOP_EN to make the program repeat
// (idx wraps to 0 after last_idx, done pulses on every wrap) until stop.
// Without the macro the program runs once and finishes through DONE.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   wr_en            in   table write strobe (accepted in IDLE/DONE only)
//   wr_addr          in   table write index
//   wr_data          in   permutation word to store
//   last_idx         in   index of final entry (captured at start)
//   dwell            in   per-entry hold length minus one (captured at start)
//   start            in   begin program (IDLE only)
//   stop             in   abort program (LOAD/HOLD); wins over start in IDLE
//   busy             out  high while in LOAD or HOLD
//   done             out  one-cycle completion pulse
//   wr_err           out  one-cycle pulse for a write dropped while busy
//   switch_selection out  per-stage switch_set vectors to the network
//   cfg_valid        out  switch_selection holds a live entry
//   cur_idx          out  index of the entry on switch_selection
// ----------------------------------------------------------------------------
module benes_cfg_sequencer #(
    parameter int SIZE       = 8,
    parameter int STAGE_NUM  = 5,
    parameter int SWITCH_NUM = 4,
    parameter int DEPTH      = 8,
    parameter int DWELL_W    = 8,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int WORD_W    = STAGE_NUM * SWITCH_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [IDX_W-1:0]      last_idx,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_err,
    output logic [SWITCH_NUM-1:0] switch_selection [0:STAGE_NUM-1],
    output logic                  cfg_valid,
    output logic [IDX_W-1:0]      cur_idx
);

    // Catch a mis-sized instantiation at elaboration rather than in the lab.
    generate
        if ((SWITCH_NUM != SIZE / 2) ||
            (STAGE_NUM != 2 * $clog2(SIZE) - 1) ||
            (DEPTH != (1 << IDX_W))) begin : g_param_check
            $error("benes_cfg_sequencer: inconsistent SIZE/STAGE_NUM/SWITCH_NUM/DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic [DWELL_W-1:0]   cnt_q,       cnt_d;
    logic [IDX_W-1:0]     last_cap_q,  last_cap_d;
    logic [DWELL_W-1:0]   dwell_cap_q, dwell_cap_d;
    logic [WORD_W-1:0]    sel_q,       sel_d;
    logic [IDX_W-1:0]     cur_idx_q,   cur_idx_d;
    logic                 cfg_valid_q, cfg_valid_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 wr_err_q,    wr_err_d;
    logic [WORD_W-1:0]    table_q [DEPTH];
    logic [WORD_W-1:0]    table_d [DEPTH];

    // The table is frozen while a program runs so the entry sequence seen
    // by the network always matches what was loaded before start.
    logic running;
    assign running = (state_q == LOAD) || (state_q == HOLD);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        last_cap_d  = last_cap_q;
        dwell_cap_d = dwell_cap_q;
        sel_d       = sel_q;
        cur_idx_d   = cur_idx_q;
        cfg_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wr_err_d    = wr_en && running;

        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (wr_en && !running) begin
            table_d[wr_addr] = wr_data;
        end

        case (state_q)
            IDLE: begin
                // stop has priority so a simultaneous start/stop is a no-op.
                if (start && !stop) begin
                    state_d     = LOAD;
                    idx_d       = '0;
                    last_cap_d  = last_idx;
                    dwell_cap_d = dwell;
                    busy_d      = 1'b1;
                end
            end

            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    state_d     = HOLD;
                    sel_d       = table_q[idx_q];
                    cur_idx_d   = idx_q;
                    cnt_d       = dwell_cap_q;
                    cfg_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d       = cnt_q - DWELL_W'(1);
                    cfg_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (idx_q < last_cap_q) begin
                    // idx only advances below last_cap_q, so it can never
                    // run past DEPTH-1.
                    state_d = LOAD;
                    idx_d   = idx_q + IDX_W'(1);
                    busy_d  = 1'b1;
                end else begin
`ifdef BENES_CFG_LOOP_EN
                    // Wrap straight back to entry 0; done marks each pass.
                    state_d = LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end
            end

            DONE: begin
                // start is deliberately ignored here; it is only seen in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_cap_q  <= '0;
            dwell_cap_q <= '0;
            sel_q       <= '0;
            cur_idx_q   <= '0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            last_cap_q  <= last_cap_d;
            dwell_cap_q <= dwell_cap_d;
            sel_q       <= sel_d;
            cur_idx_q   <= cur_idx_d;
            cfg_valid_q <= cfg_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign cfg_valid = cfg_valid_q;
    assign cur_idx   = cur_idx_q;

    // Split the stored permutation word into one switch_set vector per stage.
    generate
        for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_stage_out
            assign switch_selection[gi] = sel_q[gi*SWITCH_NUM +: SWITCH_NUM];
        end
    endgenerate

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_benes_cfg_sequencer
//
// Directed bench for benes_cfg_sequencer. A schedule model turns each
// accepted program (table snapshot, last_idx, dwell) into the list of
// per-cycle outputs it must produce: per entry one LOAD cycle followed by
// dwell+1 live cycles, then a done cycle. A compare process checks every
// output against that schedule on each falling edge; directed tests add
// hand-computed literal expectations that pin the model itself.
// ----------------------------------------------------------------------------
module tb_benes_cfg_sequencer;

    localparam int STAGE_NUM  = 5;
    localparam int SWITCH_NUM = 4;
    localparam int DEPTH      = 8;
    localparam int DWELL_W    = 8;
    localparam int IDX_W      = 3;
    localparam int WORD_W     = STAGE_NUM * SWITCH_NUM;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic                  wr_en    = 1'b0;
    logic [IDX_W-1:0]      wr_addr  = '0;
    logic [WORD_W-1:0]     wr_data  = '0;
    logic [IDX_W-1:0]      last_idx = '0;
    logic [DWELL_W-1:0]    dwell    = '0;
    logic                  start    = 1'b0;
    logic                  stop     = 1'b0;
    logic                  busy, done, wr_err, cfg_valid;
    logic [IDX_W-1:0]      cur_idx;
    logic [SWITCH_NUM-1:0] switch_selection [0:STAGE_NUM-1];
    logic [WORD_W-1:0]     sel_word;

    benes_cfg_sequencer #(
        .SIZE(8), .STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM),
        .DEPTH(DEPTH), .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .last_idx(last_idx), .dwell(dwell),
        .start(start), .stop(stop), .busy(busy), .done(done),
        .wr_err(wr_err), .switch_selection(switch_selection),
        .cfg_valid(cfg_valid), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    always_comb begin
        sel_word = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            sel_word[s*SWITCH_NUM +: SWITCH_NUM] = switch_selection[s];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Schedule model
    // ------------------------------------------------------------------
    typedef struct {
        logic              busy;
        logic              done;
        logic              valid;
        logic [WORD_W-1:0] sel;
        logic [IDX_W-1:0]  cur;
    } exp_t;

    exp_t              tl[$];
    logic              exp_busy = 1'b0, exp_done = 1'b0, exp_valid = 1'b0, exp_wr_err = 1'b0;
    logic [WORD_W-1:0] exp_sel = '0;
    logic [IDX_W-1:0]  exp_cur = '0;
    logic [WORD_W-1:0] mtable [DEPTH];
    logic [WORD_W-1:0] msnap  [DEPTH];
    int                m_last = 0, m_dwell = 0;
    bit                m_loop = 1'b0;

    function automatic exp_t mk(input logic b, input logic d, input logic v,
                                input logic [WORD_W-1:0] s, input logic [IDX_W-1:0] c);
        exp_t e;
        e.busy = b; e.done = d; e.valid = v; e.sel = s; e.cur = c;
        return e;
    endfunction

    // One pass of the program: per entry a LOAD cycle still showing the
    // previous entry, then dwell+1 live cycles of this entry.
    task automatic add_pass(input logic first_done, input logic [WORD_W-1:0] psel,
                            input logic [IDX_W-1:0] pcur);
        for (int i = 0; i <= m_last; i++) begin
            tl.push_back(mk(1'b1, first_done && (i == 0), 1'b0, psel, pcur));
            for (int k = 0; k <= m_dwell; k++) tl.push_back(mk(1'b1, 1'b0, 1'b1, msnap[i], IDX_W'(i)));
            psel = msnap[i];
            pcur = IDX_W'(i);
        end
`ifndef BENES_CFG_LOOP_EN
        tl.push_back(mk(1'b0, 1'b1, 1'b0, psel, pcur));
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin : model_p
        logic ob, od;
        exp_t e;
        if (!rst_n) begin
            tl.delete();
            m_loop = 1'b0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; exp_wr_err = 1'b0;
            exp_sel = '0; exp_cur = '0;
            for (int i = 0; i < DEPTH; i++) mtable[i] = '0;
        end else begin
            ob = exp_busy;
            od = exp_done;
            exp_wr_err = wr_en && ob;
            if (wr_en && !ob) mtable[wr_addr] = wr_data;
            if (stop && ob) begin
                tl.delete();
                m_loop = 1'b0;
            end else if (start && !stop && !ob && !od) begin
                for (int i = 0; i < DEPTH; i++) msnap[i] = mtable[i];
                m_last  = int'(last_idx);
                m_dwell = int'(dwell);
`ifdef BENES_CFG_LOOP_EN
                m_loop = 1'b1;
`endif
                add_pass(1'b0, exp_sel, exp_cur);
            end
            if (tl.size() == 0 && m_loop) add_pass(1'b1, msnap[m_last], IDX_W'(m_last));
            if (tl.size() > 0) begin
                e = tl.pop_front();
                exp_busy = e.busy; exp_done = e.done; exp_valid = e.valid;
                exp_sel = e.sel; exp_cur = e.cur;
            end else begin
                exp_busy = 1'b0; exp_done = 1'b0; exp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",      32'(busy),      32'(exp_busy));
            chk("cyc_done",      32'(done),      32'(exp_done));
            chk("cyc_cfg_valid", 32'(cfg_valid), 32'(exp_valid));
            chk("cyc_wr_err",    32'(wr_err),    32'(exp_wr_err));
            chk("cyc_sel",       32'(sel_word),  32'(exp_sel));
            chk("cyc_cur_idx",   32'(cur_idx),   32'(exp_cur));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int                w_valid [DEPTH];
    logic [WORD_W-1:0] w_sel   [DEPTH];
    int                w_done, w_first, w_done_cyc;
    bit                w_ended;

    task automatic write_entry(input int a, input logic [WORD_W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Leaves last_idx/dwell at other values afterwards so a missing capture shows.
    task automatic pulse_start(input int li, input int dw);
        @(negedge clk);
        last_idx = IDX_W'(li); dwell = DWELL_W'(dw); start = 1'b1;
        @(negedge clk);
        start = 1'b0; last_idx = 3'd7; dwell = 8'd0;
        $display("start last_idx=%0d dwell=%0d at %0t", li, dw, $time);
    endtask

    task automatic watch(input int maxc);
        for (int i = 0; i < DEPTH; i++) begin w_valid[i] = 0; w_sel[i] = '0; end
        w_done = 0; w_first = -1; w_done_cyc = -1; w_ended = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            if (cfg_valid === 1'b1) begin
                if (w_first < 0) w_first = c;
                w_valid[cur_idx]++;
                w_sel[cur_idx] = sel_word;
            end
            if (done === 1'b1) begin
                w_done++;
                if (w_done_cyc < 0) w_done_cyc = c;
            end
            if (c > 0 && busy !== 1'b1 && done !== 1'b1) begin
                w_ended = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("program_ended", 32'(w_ended), 32'd1);
    endtask

    task automatic wait_valid_idx(input int idx, input int maxc, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            if (cfg_valid === 1'b1 && cur_idx === IDX_W'(idx)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_valid", 32'(cfg_valid), 32'd0);
        chk("rst_sel",   32'(sel_word),  32'd0);
        chk("rst_cur",   32'(cur_idx),   32'd0);
        #3 rst_n = 1'b1;

`ifndef BENES_CFG_LOOP_EN
        // Three one-hot entries, last_idx=2, dwell=3.
        write_entry(0, 20'h00001);
        write_entry(1, 20'h00010);
        write_entry(2, 20'h00100);
        pulse_start(2, 3);
        watch(60);
        $display("txn basic: valid=%0d/%0d/%0d done=%0d span=%0d", w_valid[0], w_valid[1], w_valid[2], w_done, w_done_cyc - w_first);
        chk("basic_valid0", 32'(w_valid[0]), 32'd4);
        chk("basic_valid1", 32'(w_valid[1]), 32'd4);
        chk("basic_valid2", 32'(w_valid[2]), 32'd4);
        chk("basic_valid3", 32'(w_valid[3]), 32'd0);
        chk("basic_sel0",   32'(w_sel[0]),   32'h00001);
        chk("basic_sel1",   32'(w_sel[1]),   32'h00010);
        chk("basic_sel2",   32'(w_sel[2]),   32'h00100);
        chk("basic_done",   32'(w_done),     32'd1);
        // First live cycle to done cycle: 3*(dwell+1) + 2 LOAD gaps = 14.
        chk("basic_span",   32'(w_done_cyc - w_first), 32'd14);

        // Single entry, zero dwell, all switches set.
        write_entry(0, 20'hFFFFF);
        pulse_start(0, 0);
        watch(20);
        $display("txn single: valid=%0d done=%0d span=%0d", w_valid[0], w_done, w_done_cyc - w_first);
        chk("single_valid0", 32'(w_valid[0]), 32'd1);
        chk("single_valid1", 32'(w_valid[1]), 32'd0);
        chk("single_sel0",   32'(w_sel[0]),   32'hFFFFF);
        chk("single_done",   32'(w_done),     32'd1);
        chk("single_span",   32'(w_done_cyc - w_first), 32'd1);

        // start during the DONE cycle is ignored.
        pulse_start(0, 0);
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (done === 1'b1) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            chk("done_seen", 32'(seen), 32'd1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn start_in_done: busy=%0d", busy);
        chk("start_in_done_busy", 32'(busy), 32'd0);

        // stop wins over start in IDLE.
        @(negedge clk);
        last_idx = 3'd0; dwell = 8'd0; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        $display("txn start_stop: busy=%0d", busy);
        chk("start_stop_busy", 32'(busy), 32'd0);

        // Write while busy is dropped and flagged.
        write_entry(0, 20'h00001);
        pulse_start(2, 3);
        wait_valid_idx(0, 10, "wr_hold_reached");
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 20'hABCDE;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_err_pulse", 32'(wr_err), 32'd1);
        @(negedge clk);
        chk("wr_err_clear", 32'(wr_err), 32'd0);
        $display("txn busy_write: addr=1 data=0xABCDE");
        watch(60);
        pulse_start(2, 3);
        watch(60);
        $display("txn replay: sel1=0x%0h", w_sel[1]);
        chk("replay_sel1",   32'(w_sel[1]),   32'h00010);
        chk("replay_valid1", 32'(w_valid[1]), 32'd4);

        // stop on the second HOLD cycle of entry 1.
        pulse_start(2, 3);
        wait_valid_idx(1, 20, "stop_hold_reached");
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        $display("txn stop: busy=%0d valid=%0d sel=0x%0h cur=%0d", busy, cfg_valid, sel_word, cur_idx);
        chk("stop_busy",  32'(busy),      32'd0);
        chk("stop_valid", 32'(cfg_valid), 32'd0);
        chk("stop_done",  32'(done),      32'd0);
        chk("stop_sel",   32'(sel_word),  32'h00010);
        chk("stop_cur",   32'(cur_idx),   32'd1);
        begin
            int dn = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done === 1'b1) dn++;
            end
            chk("stop_no_done", 32'(dn), 32'd0);
        end

        // Asynchronous reset in the middle of HOLD.
        pulse_start(2, 3);
        wait_valid_idx(1, 20, "rst_hold_reached");
        #2 rst_n = 1'b0;
        #1;
        $display("txn async_reset: busy=%0d valid=%0d sel=0x%0h", busy, cfg_valid, sel_word);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_valid", 32'(cfg_valid), 32'd0);
        chk("arst_done",  32'(done),      32'd0);
        chk("arst_sel",   32'(sel_word),  32'd0);
        chk("arst_cur",   32'(cur_idx),   32'd0);
        chk("arst_wrerr", 32'(wr_err),    32'd0);
        // Release and start within the same cycle: first edge must take it.
        @(negedge clk);
        last_idx = 3'd2; dwell = 8'd0; start = 1'b1;
        #3 rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch(30);
        $display("txn post_reset: sel=0x%0h/0x%0h/0x%0h done=%0d", w_sel[0], w_sel[1], w_sel[2], w_done);
        chk("prst_valid0", 32'(w_valid[0]), 32'd1);
        chk("prst_valid2", 32'(w_valid[2]), 32'd1);
        chk("prst_sel0",   32'(w_sel[0]),   32'd0);
        chk("prst_sel1",   32'(w_sel[1]),   32'd0);
        chk("prst_done",   32'(w_done),     32'd1);
`else
        // Looping program: last_idx=1, dwell=1 -> pass length 2*(1+2)=6.
        write_entry(0, 20'h00001);
        write_entry(1, 20'h00010);
        pulse_start(1, 1);
        begin
            int dn = 0, nseq = 0, bad = 0;
            logic pv = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (done === 1'b1) dn++;
                if (cfg_valid === 1'b1 && pv !== 1'b1) begin
                    if (int'(cur_idx) != (nseq % 2)) bad++;
                    nseq++;
                end
                pv = cfg_valid;
                @(negedge clk);
            end
            $display("txn loop: entries=%0d order_err=%0d dones=%0d", nseq, bad, dn);
            chk("loop_entries", 32'(nseq), 32'd7);
            chk("loop_order",   32'(bad),  32'd0);
            chk("loop_dones",   32'(dn),   32'd3);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("loop_stop_busy", 32'(busy), 32'd0);
        chk("loop_stop_done", 32'(done), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
